// File: rtl/mult_div_unit.sv
// Iterative MIPS multiply/divide unit: MULT/MULTU/DIV/DIVU in WIDTH+1 cycles,
// with architectural HI/LO registers writable through MTHI/MTLO while idle.
module mult_div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

  state_e               state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic                 is_div_q, is_div_d;
  logic                 neg_res_q, neg_res_d;
  logic                 neg_rem_q, neg_rem_d;
  logic                 b_zero_q, b_zero_d;
  logic [WIDTH-1:0]     a_raw_q, a_raw_d;
  logic [WIDTH-1:0]     opb_q, opb_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic                 done_q, done_d;

  logic               is_signed;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH:0]     add_sum;
  logic [WIDTH:0]     trial, diff;
  logic               ge;
  logic [WIDTH-1:0]   rem_new;
  logic [2*WIDTH-1:0] mul_next, div_next, prod;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  assign is_signed = op[0];
  assign abs_a = (is_signed && a[WIDTH-1]) ? (~a + 1'b1) : a;
  assign abs_b = (is_signed && b[WIDTH-1]) ? (~b + 1'b1) : b;

  // Multiply: acc = {partial product, remaining multiplier bits}.
  assign add_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opb_q : '0)};
  assign mul_next = {add_sum, acc_q[WIDTH-1:1]};

  // Restoring divide: acc = {partial remainder, dividend/quotient bits}.
  assign trial    = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign diff     = trial - {1'b0, opb_q};
  assign ge       = ~diff[WIDTH];
  assign rem_new  = ge ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
  assign div_next = {rem_new, acc_q[WIDTH-2:0], ge};

  assign prod    = neg_res_q ? (~acc_q + 1'b1) : acc_q;
  assign quo_fix = neg_res_q ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
  assign rem_fix = neg_rem_q ? (~acc_q[2*WIDTH-1:WIDTH] + 1'b1) : acc_q[2*WIDTH-1:WIDTH];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    b_zero_d  = b_zero_q;
    a_raw_d   = a_raw_q;
    opb_d     = opb_q;
    acc_d     = acc_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (mthi) hi_d = wdata;
        if (mtlo) lo_d = wdata;
        if (start) begin
          is_div_d  = op[1];
          neg_res_d = is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
          neg_rem_d = is_signed && op[1] && a[WIDTH-1];
          b_zero_d  = (b == '0);
          a_raw_d   = a;
          opb_d     = abs_b;
          acc_d     = {{WIDTH{1'b0}}, abs_a};
          cnt_d     = CntW'(WIDTH);
          state_d   = StRun;
        end
      end
      StRun: begin
        acc_d = is_div_q ? div_next : mul_next;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CntW'(1)) state_d = StFix;
      end
      StFix: begin
        if (!is_div_q) begin
          hi_d = prod[2*WIDTH-1:WIDTH];
          lo_d = prod[WIDTH-1:0];
        end else if (b_zero_q) begin
          hi_d = a_raw_q;
          lo_d = '1;
        end else begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      b_zero_q  <= 1'b0;
      a_raw_q   <= '0;
      opb_q     <= '0;
      acc_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      b_zero_q  <= b_zero_d;
      a_raw_q   <= a_raw_d;
      opb_q     <= opb_d;
      acc_q     <= acc_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

  assign busy = (state_q != StIdle);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit: latency, sign rules,
// divide-by-zero, ignored requests while busy, async reset and MTHI/MTLO.
module tb_mult_div_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] a, b;
  logic         mthi, mtlo;
  logic [W-1:0] wdata;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] m_hi, m_lo;

  mult_div_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .mthi  (mthi),
    .mtlo  (mtlo),
    .wdata (wdata),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issues one operation and follows it to completion; inject>0 pulses start+mthi
  // with conflicting data on that RUN cycle to confirm they are ignored.
  task automatic do_op(input string tag, input logic [1:0] o, input logic [W-1:0] x,
                       input logic [W-1:0] y, input logic [W-1:0] e_hi,
                       input logic [W-1:0] e_lo, input int inject);
    int bad;
    start = 1'b1; op = o; a = x; b = y;
    step();
    chk({tag, "_accept_busy"}, W'(busy), W'(1));
    chk({tag, "_accept_done"}, W'(done), W'(0));
    start = 1'b0; a = 32'h5A5A5A5A; b = 32'h0000_0003; op = ~o;
    bad = 0;
    for (int i = 1; i <= W; i++) begin
      if (i == inject) begin
        start = 1'b1; mthi = 1'b1; mtlo = 1'b1; wdata = 32'hDEADBEEF;
      end
      step();
      start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
      if (done !== 1'b0 || busy !== 1'b1 || hi !== m_hi || lo !== m_lo) bad++;
    end
    chk({tag, "_run_hold"}, W'(bad), W'(0));
    step();
    chk({tag, "_done"}, W'(done), W'(1));
    chk({tag, "_busy"}, W'(busy), W'(0));
    chk({tag, "_hi"}, hi, e_hi);
    chk({tag, "_lo"}, lo, e_lo);
    m_hi = e_hi;
    m_lo = e_lo;
  endtask

  initial begin
    int bad;
    rst_n = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0;
    mthi = 1'b0; mtlo = 1'b0; wdata = '0;
    m_hi = '0; m_lo = '0;
    #2;
    chk("rst_busy", W'(busy), W'(0));
    chk("rst_done", W'(done), W'(0));
    chk("rst_hi", hi, 32'h0);
    chk("rst_lo", lo, 32'h0);
    step();
    rst_n = 1'b1;
    step();

    do_op("mult_m3x5", 2'b01, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, 0);
    step();
    chk("done_one_cycle", W'(done), W'(0));
    do_op("multu_max", 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 0);
    do_op("div_m7d2", 2'b11, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 0);
    // Back-to-back: issued during the done cycle.
    do_op("divu_100d7", 2'b10, 32'd100, 32'd7, 32'd2, 32'd14, 0);
    do_op("divu_by0", 2'b10, 32'h12345678, 32'h0, 32'h12345678, 32'hFFFFFFFF, 0);
    do_op("div_by0_neg", 2'b11, 32'hFFFFFFF9, 32'h0, 32'hFFFFFFF9, 32'hFFFFFFFF, 0);
    do_op("div_ovf", 2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 0);
    do_op("mult_ignore", 2'b01, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'h0, 32'h6, 10);
    step();
    chk("ignore_no_restart", W'(busy), W'(0));

    // mthi with start in idle: write lands, result overwrites later.
    mthi = 1'b1; wdata = 32'h00000055;
    start = 1'b1; op = 2'b00; a = 32'd7; b = 32'd9;
    step();
    mthi = 1'b0; start = 1'b0;
    chk("mthi_with_start", hi, 32'h00000055);
    m_hi = 32'h00000055;
    bad = 0;
    for (int i = 0; i < W + 4 && done !== 1'b1; i++) step();
    chk("mthi_start_res_hi", hi, 32'h0);
    chk("mthi_start_res_lo", lo, 32'd63);
    step();

    // Asynchronous reset mid-operation.
    start = 1'b1; op = 2'b01; a = 32'hFFFFFFFD; b = 32'd5;
    step();
    start = 1'b0;
    for (int i = 1; i < 20; i++) step();
    chk("pre_rst_busy", W'(busy), W'(1));
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", W'(busy), W'(0));
    chk("mid_rst_hi", hi, 32'h0);
    chk("mid_rst_lo", lo, 32'h0);
    step();
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (done !== 1'b0 || busy !== 1'b0) bad++;
    end
    chk("no_done_after_rst", W'(bad), W'(0));

    mtlo = 1'b1; wdata = 32'hCAFEF00D;
    step();
    mtlo = 1'b0;
    chk("mtlo_lo", lo, 32'hCAFEF00D);
    chk("mtlo_hi", hi, 32'h0);

    mthi = 1'b1; mtlo = 1'b1; wdata = 32'h0BADF00D;
    step();
    mthi = 1'b0; mtlo = 1'b0;
    chk("both_hi", hi, 32'h0BADF00D);
    chk("both_lo", lo, 32'h0BADF00D);
    step();
    chk("hold_hi", hi, 32'h0BADF00D);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
